xnor_lfsr_bank: RTL and testbench
=================================

// Module: xnor_lfsr_bank
// PURPOSE
//  CHANNELS independent WIDTH-bit Fibonacci LFSRs with XNOR feedback.
//  Each channel has its own prescaler and can be seeded at run time.
//  Provides noise/pseudo-random sources for the audio DSP and video dither
//  paths. Generalises the single XNOR gate to a parametrised, clocked XNOR
//  parity-feedback generator.
// PARAMETERS
//  WIDTH     16        LFSR state width, >=3
//  TAPS      16'hB400  feedback mask: state[i] feeds the XNOR when TAPS[i]=1
//  CHANNELS  4         number of independent generators, >=1
//  DIV_W     8         prescaler reload width per channel
// PORTS
//  CLK        in   1                  system clock, all logic on rising edge
//  RESETL     in   1                  synchronous reset, active low
//  LOAD       in   1                  seed-load strobe, one cycle
//  LOAD_CH    in   max(1,$clog2(CH))  channel to seed; out-of-range ignored
//  LOAD_VAL   in   WIDTH              seed value
//  EN         in   CHANNELS           per-channel run enable
//  DIV        in   CHANNELS*DIV_W     per-channel prescaler reload, ch0 in LSBs
//  STATE_OUT  out  CHANNELS*WIDTH     registered LFSR state, ch0 in LSBs
//  BIT_OUT    out  CHANNELS           state[WIDTH-1] of each channel
//  STEP       out  CHANNELS           1-cycle pulse: channel advanced this cycle
//  WRAP       out  CHANNELS           1-cycle pulse: step landed on all-zeros
//  LOCK_ERR   out  1                  sticky: an all-ones seed was rejected
// BEHAVIOUR
//  - Reset (RESETL=0 at edge): state=0, prescaler count=0, STEP=WRAP=0,
//    LOCK_ERR=0, for all channels. Reset mid-run aborts any pending step or load.
//  - Step: fb = ~^(state & TAPS); state <= {state[WIDTH-2:0], fb}.
//    All-zeros is a legal state. All-ones is the XNOR lock-up state and never
//    occurs.
//  - Prescaler: when EN[c]=1 and cnt=0, channel steps and cnt <= DIV[c].
//    When EN[c]=1 and cnt!=0, cnt decrements. DIV=0 means a step every cycle;
//    DIV=n means one step every n+1 cycles.
//  - EN[c]=0: state and cnt hold, STEP[c]=0.
//  - STEP and WRAP are registered and coincide with the STATE_OUT update.
//    WRAP[c]=1 only when the new state is all-zeros.
//  - Load: LOAD=1 and LOAD_CH=c<CHANNELS gives state <= LOAD_VAL and cnt <= DIV[c].
//    Load takes priority over a same-cycle step (STEP[c]=0 that cycle).
//    Load does not assert WRAP.
//  - Seed all-ones: the state is loaded as all-zeros instead, and LOCK_ERR is
//    set to 1. It clears only on reset.
//  - Loads to other channels do not disturb their neighbours.
//  - Latency: input to STATE_OUT is 1 cycle, for both load and step.
// STRUCTURE
//  - Package lfsr_pkg: default TAPS constants for widths 4..24, and the
//    function xnor_fb(state, taps) returning the feedback bit.
//  - Sub-module lfsr_chan (one channel: state register, prescaler, STEP/WRAP).
//    The top instantiates it CHANNELS times with a generate loop and ORs the
//    per-channel lock-reject into LOCK_ERR.
// TESTING
//  1. Reset: hold RESETL=0 for 3 cycles with EN all-ones.
//     -> STATE_OUT=0, STEP=WRAP=0, LOCK_ERR=0.
//  2. WIDTH=4, TAPS=4'b1100, DIV=0, EN[0]=1, starting from 0000.
//     -> sequence 1,3,7,E,D,B,6,C,9,2,5,A,4,8,0.
//     -> WRAP[0] on the 15th step only; period 15; state never F.
//  3. DIV[1]=3, EN[1]=1.
//     -> STEP[1] pulses every 4th cycle; state holds between pulses.
//     -> Drop EN for 5 cycles: no change. Re-raise: cadence resumes from the
//        held count.
//  4. LOAD ch2 with 0x1234 while EN[2]=1 and a step is due.
//     -> next cycle STATE_OUT ch2=0x1234, STEP[2]=0, cnt reloaded.
//     -> other channels continue unchanged.
//  5. LOAD ch0 with 0xFFFF.
//     -> ch0 state 0x0000, LOCK_ERR=1 and it stays 1 across later valid loads
//        until RESETL=0.
//  6. Pulse RESETL=0 for 1 cycle mid-run with a LOAD asserted the same cycle.
//     -> all states 0, LOAD ignored, LOCK_ERR=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR LFSR bank: maximal-length tap masks and
// the XNOR parity feedback function used by every channel.
package lfsr_pkg;

  localparam int MAX_W = 64;

  // Masks use bit (t-1) for tap t, so the MSB is always part of the feedback.
  function automatic logic [MAX_W-1:0] default_taps(input int w);
    logic [MAX_W-1:0] taps;
    taps = '0;
    case (w)
      4:       taps = 64'h0000_000C;
      5:       taps = 64'h0000_0014;
      6:       taps = 64'h0000_0030;
      7:       taps = 64'h0000_0060;
      8:       taps = 64'h0000_00B8;
      9:       taps = 64'h0000_0110;
      10:      taps = 64'h0000_0240;
      11:      taps = 64'h0000_0500;
      12:      taps = 64'h0000_0829;
      13:      taps = 64'h0000_100D;
      14:      taps = 64'h0000_2015;
      15:      taps = 64'h0000_6000;
      16:      taps = 64'h0000_B400;
      17:      taps = 64'h0001_2000;
      18:      taps = 64'h0002_0400;
      19:      taps = 64'h0004_0023;
      20:      taps = 64'h0009_0000;
      21:      taps = 64'h0014_0000;
      22:      taps = 64'h0030_0000;
      23:      taps = 64'h0042_0000;
      24:      taps = 64'h00E1_0000;
      default: taps = '0;
    endcase
    return taps;
  endfunction

  function automatic logic xnor_fb(input logic [MAX_W-1:0] state,
                                   input logic [MAX_W-1:0] taps);
    return ~^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One XNOR Fibonacci LFSR channel with its own prescaler, seed load and
// lock-up seed rejection.
module lfsr_chan
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int               DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] state,
  output logic             step,
  output logic             wrap,
  output logic             lock_rej
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             lock_q, lock_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {state_q[WIDTH-2:0],
                    xnor_fb(MAX_W'(state_q), MAX_W'(TAPS))};

  // An all-ones seed would freeze an XNOR LFSR, so it is replaced by zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    lock_d  = lock_q;
    if (load) begin
      cnt_d = div;
      if (load_val == '1) begin
        state_d = '0;
        lock_d  = 1'b1;
      end else begin
        state_d = load_val;
      end
    end else if (en) begin
      if (cnt_q == '0) begin
        state_d = shifted;
        cnt_d   = div;
        step_d  = 1'b1;
        wrap_d  = (shifted == '0);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      lock_q  <= lock_d;
    end
  end

  assign state    = state_q;
  assign step     = step_q;
  assign wrap     = wrap_q;
  assign lock_rej = lock_q;

endmodule

// File: rtl/xnor_lfsr_bank.sv
// Bank of independent XNOR-feedback LFSR noise generators, each with its own
// prescaler and run-time seed load.
module xnor_lfsr_bank
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter int               CHANNELS = 4,
  parameter int               DIV_W    = 8,
  localparam int              LCH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RESETL,
  input  logic                      LOAD,
  input  logic [LCH_W-1:0]          LOAD_CH,
  input  logic [WIDTH-1:0]          LOAD_VAL,
  input  logic [CHANNELS-1:0]       EN,
  input  logic [CHANNELS*DIV_W-1:0] DIV,
  output logic [CHANNELS*WIDTH-1:0] STATE_OUT,
  output logic [CHANNELS-1:0]       BIT_OUT,
  output logic [CHANNELS-1:0]       STEP,
  output logic [CHANNELS-1:0]       WRAP,
  output logic                      LOCK_ERR
);

  logic [CHANNELS-1:0] lock_vec;

  // Channel indices that do not fit in CHANNELS never match, so those loads drop.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic             chan_load;
    logic [WIDTH-1:0] chan_state;

    assign chan_load = LOAD && (LOAD_CH == LCH_W'(c));

    lfsr_chan #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .DIV_W (DIV_W)
    ) u_chan (
      .clk      (CLK),
      .rst_n    (RESETL),
      .load     (chan_load),
      .load_val (LOAD_VAL),
      .en       (EN[c]),
      .div      (DIV[c*DIV_W +: DIV_W]),
      .state    (chan_state),
      .step     (STEP[c]),
      .wrap     (WRAP[c]),
      .lock_rej (lock_vec[c])
    );

    assign STATE_OUT[c*WIDTH +: WIDTH] = chan_state;
    assign BIT_OUT[c]                  = chan_state[WIDTH-1];
  end

  assign LOCK_ERR = |lock_vec;

endmodule

// File: tb/tb_xnor_lfsr_bank.sv
// Self-checking bench for xnor_lfsr_bank: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_xnor_lfsr_bank;

  localparam int               W    = 16;
  localparam int               CH   = 4;
  localparam int               DW   = 8;
  localparam logic [W-1:0]     TAPS = 16'hB400;

  logic            clk = 1'b0;
  logic            resetl;
  logic            load;
  logic [1:0]      load_ch;
  logic [W-1:0]    load_val;
  logic [CH-1:0]   en;
  logic [CH*DW-1:0] div;
  logic [CH*W-1:0] state_out;
  logic [CH-1:0]   bit_out, step, wrap;
  logic            lock_err;

  logic            s_load, s_load_ch, s_en;
  logic [3:0]      s_load_val;
  logic [7:0]      s_div;
  logic [3:0]      s_state;
  logic            s_bit, s_step, s_wrap, s_lock;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [W-1:0]  m_state [CH];
  int            m_cnt   [CH];
  logic [CH-1:0] m_step, m_wrap;
  logic          m_lock;

  always #5 clk = ~clk;

  xnor_lfsr_bank #(.WIDTH(W), .TAPS(TAPS), .CHANNELS(CH), .DIV_W(DW)) dut (
    .CLK(clk), .RESETL(resetl), .LOAD(load), .LOAD_CH(load_ch),
    .LOAD_VAL(load_val), .EN(en), .DIV(div), .STATE_OUT(state_out),
    .BIT_OUT(bit_out), .STEP(step), .WRAP(wrap), .LOCK_ERR(lock_err)
  );

  xnor_lfsr_bank #(.WIDTH(4), .TAPS(4'b1100), .CHANNELS(1), .DIV_W(8)) dut4 (
    .CLK(clk), .RESETL(resetl), .LOAD(s_load), .LOAD_CH(s_load_ch),
    .LOAD_VAL(s_load_val), .EN(s_en), .DIV(s_div), .STATE_OUT(s_state),
    .BIT_OUT(s_bit), .STEP(s_step), .WRAP(s_wrap), .LOCK_ERR(s_lock)
  );

  // Next state from the parity rule: feedback is 1 when the tapped bits hold an even count of ones.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int w,
                                            input logic [31:0] taps);
    logic [31:0] fb;
    fb = ($countones(s & taps) % 2 == 0) ? 32'd1 : 32'd0;
    return ((s << 1) | fb) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [W-1:0] st(input int c);
    return state_out[c*W +: W];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_l, input logic ld,
                               input logic [1:0] ch, input logic [W-1:0] val,
                               input logic [CH-1:0] e, input logic [31:0] d);
    resetl   = rst_l;
    load     = ld;
    load_ch  = ch;
    load_val = val;
    en       = e;
    div      = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_state[c] = '0;
      m_cnt[c]   = 0;
    end
    m_step = '0;
    m_wrap = '0;
    m_lock = 1'b0;
  end

  always @(posedge clk) begin
    if (!resetl) begin
      for (int c = 0; c < CH; c++) begin
        m_state[c] = '0;
        m_cnt[c]   = 0;
      end
      m_step = '0;
      m_wrap = '0;
      m_lock = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_step[c] = 1'b0;
        m_wrap[c] = 1'b0;
        if (load && int'(load_ch) == c) begin
          m_cnt[c] = int'(div[c*DW +: DW]);
          if (load_val == 16'hFFFF) begin
            m_state[c] = '0;
            m_lock     = 1'b1;
          end else begin
            m_state[c] = load_val;
          end
        end else if (en[c]) begin
          if (m_cnt[c] == 0) begin
            m_state[c] = W'(lfsr_next(32'(m_state[c]), W, 32'(TAPS)));
            m_cnt[c]   = int'(div[c*DW +: DW]);
            m_step[c]  = 1'b1;
            m_wrap[c]  = (m_state[c] == '0);
          end else begin
            m_cnt[c] = m_cnt[c] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [CH-1:0] exp_bit;
      for (int c = 0; c < CH; c++) begin
        checkOutput($sformatf("model_state_ch%0d", c), 64'(st(c)), 64'(m_state[c]));
        exp_bit[c] = m_state[c][W-1];
      end
      checkOutput("model_bit_out", 64'(bit_out), 64'(exp_bit));
      checkOutput("model_step", 64'(step), 64'(m_step));
      checkOutput("model_wrap", 64'(wrap), 64'(m_wrap));
      checkOutput("model_lock_err", 64'(lock_err), 64'(m_lock));
    end
  end

  initial begin
    logic [3:0]  seq [15];
    logic [W-1:0] prev;
    logic [31:0] d;
    seq = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
            4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

    s_load = 1'b0; s_load_ch = 1'b0; s_load_val = 4'h0; s_en = 1'b0; s_div = 8'h00;
    resetl = 1'b0; load = 1'b0; load_ch = 2'd0; load_val = '0; en = '1; div = '0;
    @(posedge clk);
    #1;

    // Reset held with every channel enabled.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 16'h0, 4'hF, 32'h0);
      check_en = 1'b1;
    end
    checkOutput("reset_state", 64'(state_out), 64'h0);
    checkOutput("reset_step", 64'(step), 64'h0);
    checkOutput("reset_wrap", 64'(wrap), 64'h0);
    checkOutput("reset_lock", 64'(lock_err), 64'h0);
    checkOutput("reset_small_state", 64'(s_state), 64'h0);

    // 4-bit channel walks the full 15-state cycle twice.
    for (int k = 0; k < 15; k++)
      checkOutput($sformatf("model_seq4_%0d", k),
                  64'(lfsr_next(32'(k == 0 ? 4'h0 : seq[k-1]), 4, 32'hC)), 64'(seq[k]));
    s_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'h0, 32'h0);
      checkOutput($sformatf("seq4_state_%0d", k), 64'(s_state), 64'(seq[k % 15]));
      checkOutput($sformatf("seq4_wrap_%0d", k), 64'(s_wrap), 64'(k % 15 == 14));
      checkOutput($sformatf("seq4_step_%0d", k), 64'(s_step), 64'h1);
    end
    s_en = 1'b0;
    s_load = 1'b1; s_load_ch = 1'b1; s_load_val = 4'h5;
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'h0, 32'h0);
    checkOutput("small_oob_load_ignored", 64'(s_state), 64'h0);
    s_load_ch = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'h0, 32'h0);
    checkOutput("small_load", 64'(s_state), 64'h5);
    s_load = 1'b0;

    // Channel 1 prescaled by 4, paused mid-count, then resumed.
    d = 32'h0000_0300;
    prev = st(1);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'b0010, d);
      checkOutput($sformatf("t3_step_%0d", j), 64'(step[1]), 64'(j % 4 == 0));
      if (j % 4 == 0)
        checkOutput($sformatf("t3_moved_%0d", j), 64'(st(1) != prev), 64'h1);
      else
        checkOutput($sformatf("t3_hold_%0d", j), 64'(st(1)), 64'(prev));
      prev = st(1);
    end
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'b0000, d);
      checkOutput($sformatf("t3_paused_step_%0d", j), 64'(step[1]), 64'h0);
      checkOutput($sformatf("t3_paused_state_%0d", j), 64'(st(1)), 64'(prev));
    end
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'b0010, d);
      checkOutput($sformatf("t3_resume_step_%0d", j), 64'(step[1]), 64'(j % 4 == 2));
    end

    // Load beats a due step on channel 2.
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'b0110, d);
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'b0110, d);
    applyStimulus(1'b1, 1'b1, 2'd2, 16'h1234, 4'b0110, d);
    checkOutput("t4_loaded", 64'(st(2)), 64'h1234);
    checkOutput("t4_no_step", 64'(step[2]), 64'h0);
    checkOutput("t4_no_wrap", 64'(wrap[2]), 64'h0);
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'b0110, d);
    checkOutput("t4_next", 64'(st(2)), 64'h2468);
    checkOutput("t4_next_step", 64'(step[2]), 64'h1);

    // All-ones seed is rejected and the error is sticky.
    applyStimulus(1'b1, 1'b1, 2'd0, 16'hFFFF, 4'b0000, d);
    checkOutput("t5_zero_seed", 64'(st(0)), 64'h0);
    checkOutput("t5_lock", 64'(lock_err), 64'h1);
    checkOutput("t5_no_wrap", 64'(wrap[0]), 64'h0);
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h00AA, 4'b0000, d);
    checkOutput("t5_valid_seed", 64'(st(0)), 64'h00AA);
    checkOutput("t5_lock_sticky", 64'(lock_err), 64'h1);
    for (int j = 0; j < 3; j++)
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0, 4'hF, d);
    checkOutput("t5_lock_later", 64'(lock_err), 64'h1);

    // One-cycle reset with a competing load.
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h5555, 4'hF, d);
    checkOutput("t6_state", 64'(state_out), 64'h0);
    checkOutput("t6_lock", 64'(lock_err), 64'h0);
    checkOutput("t6_step", 64'(step), 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] v;
      if ($urandom_range(0, 15) == 0)
        for (int c = 0; c < CH; c++) d[c*DW +: DW] = 8'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                    2'($urandom_range(0, 3)), v, 4'($urandom), d);
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
